// File: rtl/mcdt_pkg.sv
// mcdt_pkg: shared channel constants and types for the mcdt transmit and receive sides
package mcdt_pkg;
    localparam int CH_NUM = 3;
    localparam int ID_W = 2;
    typedef logic [ID_W-1:0] chnl_id_t;
    localparam chnl_id_t ID_BAD = 2'd3;
    localparam int DEF_DW = 32;
    localparam int DEF_DEPTH = 32;
endpackage

// File: rtl/mcdt_rx_fifo.sv
// mcdt_rx_fifo: single-clock first-word-fall-through FIFO for one receive channel
// Ports: clk_i/rst_i clock and sync active-high reset; push_i/data_i write request;
// pop_i read request (ignored when empty); data_o head word (0 when empty);
// valid_o non-empty; count_o stored words; margin_o registered free entries.
module mcdt_rx_fifo
    import mcdt_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            data_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   margin_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_margin;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_cnt_nxt;
    // fullness and emptiness are judged on the pre-edge count, so a pop never
    // makes room for a same-cycle push and a push never feeds a same-cycle pop
    assign w_push    = push_i && (r_cnt != FULL_CNT);
    assign w_pop     = pop_i && (r_cnt != '0);
    assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign valid_o   = (r_cnt != '0);
    assign data_o    = valid_o ? r_mem[r_rp] : '0;
    assign count_o   = r_cnt;
    assign margin_o  = r_margin;
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wp] <= data_i;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_margin <= FULL_CNT;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt    <= w_cnt_nxt;
            r_margin <= FULL_CNT - w_cnt_nxt;
        end
    end
endmodule

// File: rtl/mcdt_rx.sv
// mcdt_rx: demultiplexes the mcdt output stream into three per-channel FWFT FIFOs
// Ports: clk_i/rst_i clock and sync active-high reset; mcdt_data_i/mcdt_val_i/mcdt_id_i
// incoming stream (no backpressure); chN_data_o/chN_valid_o/chN_ready_i per-channel
// drain handshake; chN_margin_o free entries; chN_drop_o saturating count of words lost
// to a full FIFO; bad_id_o one-cycle pulse after a valid word with id 3.
module mcdt_rx
    import mcdt_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DW-1:0]            mcdt_data_i,
    input  logic                     mcdt_val_i,
    input  logic [1:0]               mcdt_id_i,
    output logic [DW-1:0]            ch0_data_o,
    output logic                     ch0_valid_o,
    input  logic                     ch0_ready_i,
    output logic [$clog2(DEPTH):0]   ch0_margin_o,
    output logic [CW-1:0]            ch0_drop_o,
    output logic [DW-1:0]            ch1_data_o,
    output logic                     ch1_valid_o,
    input  logic                     ch1_ready_i,
    output logic [$clog2(DEPTH):0]   ch1_margin_o,
    output logic [CW-1:0]            ch1_drop_o,
    output logic [DW-1:0]            ch2_data_o,
    output logic                     ch2_valid_o,
    input  logic                     ch2_ready_i,
    output logic [$clog2(DEPTH):0]   ch2_margin_o,
    output logic [CW-1:0]            ch2_drop_o,
    output logic                     bad_id_o
);
    localparam int MW = $clog2(DEPTH) + 1;
    logic [CH_NUM-1:0] w_push;
    logic [CH_NUM-1:0] w_full;
    logic [CH_NUM-1:0] w_ready;
    logic [CH_NUM-1:0] w_valid;
    logic [DW-1:0]     w_data [CH_NUM];
    logic [MW-1:0]     w_count [CH_NUM];
    logic [MW-1:0]     w_margin [CH_NUM];
    logic [CW-1:0]     r_drop [CH_NUM];
    logic              r_bad_id;
    assign w_ready = {ch2_ready_i, ch1_ready_i, ch0_ready_i};
    genvar i;
    generate
        for (i = 0; i < CH_NUM; i++) begin : g_ch
            assign w_push[i] = mcdt_val_i && (mcdt_id_i == chnl_id_t'(i));
            assign w_full[i] = (w_count[i] == MW'(DEPTH));
            mcdt_rx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .push_i   (w_push[i]),
                .data_i   (mcdt_data_i),
                .pop_i    (w_ready[i]),
                .data_o   (w_data[i]),
                .valid_o  (w_valid[i]),
                .count_o  (w_count[i]),
                .margin_o (w_margin[i])
            );
        end
    endgenerate
    // a drop is counted whenever a push meets a full FIFO, and sticks at all-ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < CH_NUM; k++) r_drop[k] <= '0;
            r_bad_id <= 1'b0;
        end else begin
            for (int k = 0; k < CH_NUM; k++)
                if (w_push[k] && w_full[k] && (r_drop[k] != '1)) r_drop[k] <= r_drop[k] + 1'b1;
            r_bad_id <= mcdt_val_i && (mcdt_id_i == ID_BAD);
        end
    end
    assign ch0_data_o   = w_data[0];
    assign ch0_valid_o  = w_valid[0];
    assign ch0_margin_o = w_margin[0];
    assign ch0_drop_o   = r_drop[0];
    assign ch1_data_o   = w_data[1];
    assign ch1_valid_o  = w_valid[1];
    assign ch1_margin_o = w_margin[1];
    assign ch1_drop_o   = r_drop[1];
    assign ch2_data_o   = w_data[2];
    assign ch2_valid_o  = w_valid[2];
    assign ch2_margin_o = w_margin[2];
    assign ch2_drop_o   = r_drop[2];
    assign bad_id_o     = r_bad_id;
endmodule

// File: tb/tb_mcdt_rx.sv
// tb_mcdt_rx: randomized and directed checks of mcdt_rx against a queue-based reference
module tb_mcdt_rx;
    localparam int DW = 32;
    localparam int DEPTH = 32;
    localparam int CW = 4;
    localparam int MW = 6;
    localparam int DMAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic val = 1'b0;
    logic [1:0] id = 2'd0;
    logic [DW-1:0] din = '0;
    logic [2:0] rdy = 3'b000;
    logic [2:0][DW-1:0] dout;
    logic [2:0] vld;
    logic [2:0][MW-1:0] mar;
    logic [2:0][CW-1:0] drp;
    logic bad;
    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] q [3][$];
    int mdrop [3];
    bit mbad;
    logic [DW-1:0] e_d;
    logic [MW-1:0] e_m;

    always #5 clk = ~clk;

    mcdt_rx #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .mcdt_data_i(din), .mcdt_val_i(val), .mcdt_id_i(id),
        .ch0_data_o(dout[0]), .ch0_valid_o(vld[0]), .ch0_ready_i(rdy[0]), .ch0_margin_o(mar[0]), .ch0_drop_o(drp[0]),
        .ch1_data_o(dout[1]), .ch1_valid_o(vld[1]), .ch1_ready_i(rdy[1]), .ch1_margin_o(mar[1]), .ch1_drop_o(drp[1]),
        .ch2_data_o(dout[2]), .ch2_valid_o(vld[2]), .ch2_ready_i(rdy[2]), .ch2_margin_o(mar[2]), .ch2_drop_o(drp[2]),
        .bad_id_o(bad)
    );

    // drives one cycle of stimulus, advances the reference across the edge, settles 1 time unit
    task automatic tick(input logic r, input logic v, input logic [1:0] i, input logic [DW-1:0] d, input logic [2:0] rd);
        rst = r; val = v; id = i; din = d; rdy = rd;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                q[k].delete();
                mdrop[k] = 0;
            end
            mbad = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit pop;
                pop = rd[k] && (q[k].size() > 0);
                if (v && (i == k)) begin
                    if (q[k].size() == DEPTH) mdrop[k] = (mdrop[k] == DMAX) ? DMAX : mdrop[k] + 1;
                    else q[k].push_back(d);
                end
                if (pop) void'(q[k].pop_front());
            end
            mbad = v && (i == 2'd3);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 10; n++) tick(1'b1, 1'b0, 2'd0, '0, 3'b000);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (vld[k] !== 1'b0 || dout[k] !== '0 || mar[k] !== MW'(DEPTH) || drp[k] !== '0) begin
                miscompares++;
                $display("FAIL reset ch%0d: valid=%b data=%h margin=%0d drop=%0d, required 0 0 32 0", k, vld[k], dout[k], mar[k], drp[k]);
            end
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL reset bad_id: got %b, required 0", bad);
        end
    endtask

    task automatic test_routing();
        for (int n = 0; n < 32; n++) begin
            if (n < 30) tick(1'b0, 1'b1, 2'(n / 10), {8'h00, 8'hC0 + 8'(n / 10), 16'(n % 10)}, 3'b111);
            else tick(1'b0, 1'b0, 2'd0, '0, 3'b111);
            for (int k = 0; k < 3; k++) begin
                e_d = q[k].size() > 0 ? q[k][0] : '0;
                e_m = MW'(DEPTH - q[k].size());
                vectors++;
                if (vld[k] !== (q[k].size() > 0) || dout[k] !== e_d || mar[k] !== e_m) begin
                    miscompares++;
                    $display("FAIL routing ch%0d cyc%0d: valid=%b data=%h margin=%0d, required %b %h %0d", k, n, vld[k], dout[k], mar[k], q[k].size() > 0, e_d, e_m);
                end
            end
        end
    endtask

    task automatic test_overflow();
        for (int n = 0; n < 54 + 34; n++) begin
            if (n < 54) tick(1'b0, 1'b1, 2'd0, 32'hA000_0000 + 32'(n), 3'b110);
            else tick(1'b0, 1'b0, 2'd0, '0, 3'b111);
            e_d = q[0].size() > 0 ? q[0][0] : '0;
            e_m = MW'(DEPTH - q[0].size());
            vectors++;
            if (vld[0] !== (q[0].size() > 0) || dout[0] !== e_d || mar[0] !== e_m || drp[0] !== CW'(mdrop[0])) begin
                miscompares++;
                $display("FAIL overflow cyc%0d: valid=%b data=%h margin=%0d drop=%0d, required %b %h %0d %0d", n, vld[0], dout[0], mar[0], drp[0], q[0].size() > 0, e_d, e_m, mdrop[0]);
            end
        end
    endtask

    task automatic test_full_pop();
        for (int n = 0; n < 32; n++) tick(1'b0, 1'b1, 2'd1, 32'hB100_0000 + 32'(n), 3'b000);
        tick(1'b0, 1'b1, 2'd1, 32'h0000_DEAD, 3'b010);
        vectors++;
        if (mar[1] !== MW'(1) || drp[1] !== CW'(1) || dout[1] !== 32'hB100_0001) begin
            miscompares++;
            $display("FAIL full_pop: margin=%0d drop=%0d head=%h, required 1 1 b1000001", mar[1], drp[1], dout[1]);
        end
        for (int n = 0; n < 32; n++) begin
            tick(1'b0, 1'b0, 2'd0, '0, 3'b010);
            e_d = q[1].size() > 0 ? q[1][0] : '0;
            vectors++;
            if (dout[1] !== e_d || mar[1] !== MW'(DEPTH - q[1].size())) begin
                miscompares++;
                $display("FAIL full_pop drain cyc%0d: data=%h margin=%0d, required %h %0d", n, dout[1], mar[1], e_d, DEPTH - q[1].size());
            end
        end
    endtask

    task automatic test_bad_id();
        logic [4:0] pat = 5'b01101;
        for (int n = 0; n < 7; n++) begin
            if (n < 5) tick(1'b0, pat[n], 2'd3, 32'h0000_BAD0, 3'b111);
            else tick(1'b0, 1'b0, 2'd3, 32'h0000_BAD0, 3'b111);
            vectors++;
            if (bad !== mbad || vld !== 3'b000 || mar[0] !== MW'(DEPTH) || mar[1] !== MW'(DEPTH) || mar[2] !== MW'(DEPTH)) begin
                miscompares++;
                $display("FAIL bad_id cyc%0d: bad=%b valid=%b margins=%0d/%0d/%0d, required bad=%b valid=000 margins 32", n, bad, vld, mar[0], mar[1], mar[2], mbad);
            end
        end
    endtask

    task automatic test_back_to_back_reset();
        for (int n = 0; n < 60; n++) begin
            tick(n == 25, n < 40, 2'd2, 32'hC200_0000 + 32'(n), {n[0], 2'b11});
            e_d = q[2].size() > 0 ? q[2][0] : '0;
            e_m = MW'(DEPTH - q[2].size());
            vectors++;
            if (vld[2] !== (q[2].size() > 0) || dout[2] !== e_d || mar[2] !== e_m || drp[2] !== CW'(mdrop[2])) begin
                miscompares++;
                $display("FAIL backpressure cyc%0d: valid=%b data=%h margin=%0d drop=%0d, required %b %h %0d %0d", n, vld[2], dout[2], mar[2], drp[2], q[2].size() > 0, e_d, e_m, mdrop[2]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            tick($urandom_range(0, 99) == 0, 1'($urandom), 2'($urandom), $urandom, 3'($urandom | $urandom));
            for (int k = 0; k < 3; k++) begin
                e_d = q[k].size() > 0 ? q[k][0] : '0;
                e_m = MW'(DEPTH - q[k].size());
                vectors++;
                if (vld[k] !== (q[k].size() > 0) || dout[k] !== e_d || mar[k] !== e_m || drp[k] !== CW'(mdrop[k])) begin
                    miscompares++;
                    $display("FAIL random ch%0d cyc%0d: valid=%b data=%h margin=%0d drop=%0d, required %b %h %0d %0d", k, n, vld[k], dout[k], mar[k], drp[k], q[k].size() > 0, e_d, e_m, mdrop[k]);
                end
            end
            vectors++;
            if (bad !== mbad) begin
                miscompares++;
                $display("FAIL random bad_id cyc%0d: got %b, required %b", n, bad, mbad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_overflow();
        test_full_pop();
        test_bad_id();
        test_back_to_back_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
